// File: rtl/ch1_sweep_freq.sv
// Square channel 1 frequency datapath: frequency register, sweep shadow shifter,
// sweep adder/subtractor and 11-bit period counter with overflow pulse.
module ch1_sweep_freq #(
    parameter int unsigned FREQ_W = 11
) (
    input  logic              ajer_2mhz,
    input  logic              apu_reset,
    input  logic [7:0]        d,
    input  logic              apu_wr,
    input  logic              ff13,
    input  logic              ff14,
    input  logic              ff10_d3,
    input  logic              ch1_restart,
    input  logic              ch1_ld_shift,
    input  logic              ch1_shift_clk,
    input  logic              ch1_freq_upd1,
    input  logic              ch1_freq_upd2,
    input  logic              cnt_tick,
    output logic [FREQ_W-1:0] freq,
    output logic              copu,
    output logic              atys
);

    logic [FREQ_W-1:0] r_freq;
    logic [FREQ_W-1:0] r_sh;
    logic [FREQ_W-1:0] r_cnt;
    logic              r_copu;

    logic [FREQ_W-1:0] w_diff;
    logic [FREQ_W:0]   w_sum;
    logic              w_atys;
    logic [FREQ_W-1:0] w_freq_nxt;
    logic              w_ovf;

    always_comb begin
        w_diff = r_freq - r_sh;
        if (ff10_d3) begin
            w_sum = {1'b0, w_diff};
        end else begin
            w_sum = {1'b0, r_freq} + {1'b0, r_sh};
        end
        w_atys = !(!ff10_d3 && w_sum[FREQ_W]);

        // Sweep commit first, then CPU byte writes override only the bits they touch
        w_freq_nxt = r_freq;
        if (ch1_freq_upd1 && w_atys) begin
            w_freq_nxt = w_sum[FREQ_W-1:0];
        end
        if (apu_wr && ff13) begin
            w_freq_nxt[7:0] = d;
        end
        if (apu_wr && ff14) begin
            w_freq_nxt[FREQ_W-1:8] = d[FREQ_W-9:0];
        end

        w_ovf = cnt_tick && (r_cnt == '1);
    end

    always_ff @(posedge ajer_2mhz) begin
        if (apu_reset) begin
            r_freq <= '0;
            r_sh   <= '0;
            r_cnt  <= '0;
            r_copu <= 1'b0;
        end else begin
            r_freq <= w_freq_nxt;

            if (ch1_freq_upd2 || ch1_ld_shift) begin
                r_sh <= r_freq;
            end else if (ch1_shift_clk) begin
                r_sh <= r_sh >> 1;
            end

            if (ch1_restart) begin
                r_cnt  <= r_freq;
                r_copu <= 1'b0;
            end else if (w_ovf) begin
                r_cnt  <= r_freq;
                r_copu <= 1'b1;
            end else begin
                if (cnt_tick) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_copu <= 1'b0;
            end
        end
    end

    assign freq = r_freq;
    assign copu = r_copu;
    assign atys = w_atys;

endmodule

// File: tb/tb_ch1_sweep_freq.sv
// Scoreboard bench for ch1_sweep_freq: expected output values are queued with
// each stimulus cycle and compared one clock edge later.
module tb_ch1_sweep_freq;

    logic        clk = 1'b0;
    logic        apu_reset = 1'b0;
    logic [7:0]  d = '0;
    logic        apu_wr = 1'b0;
    logic        ff13 = 1'b0;
    logic        ff14 = 1'b0;
    logic        ff10_d3 = 1'b0;
    logic        ch1_restart = 1'b0;
    logic        ch1_ld_shift = 1'b0;
    logic        ch1_shift_clk = 1'b0;
    logic        ch1_freq_upd1 = 1'b0;
    logic        ch1_freq_upd2 = 1'b0;
    logic        cnt_tick = 1'b0;
    logic [10:0] freq;
    logic        copu;
    logic        atys;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];

    localparam int S_FREQ = 0;
    localparam int S_COPU = 1;
    localparam int S_ATYS = 2;

    ch1_sweep_freq #(.FREQ_W(11)) dut (
        .ajer_2mhz     (clk),
        .apu_reset     (apu_reset),
        .d             (d),
        .apu_wr        (apu_wr),
        .ff13          (ff13),
        .ff14          (ff14),
        .ff10_d3       (ff10_d3),
        .ch1_restart   (ch1_restart),
        .ch1_ld_shift  (ch1_ld_shift),
        .ch1_shift_clk (ch1_shift_clk),
        .ch1_freq_upd1 (ch1_freq_upd1),
        .ch1_freq_upd2 (ch1_freq_upd2),
        .cnt_tick      (cnt_tick),
        .freq          (freq),
        .copu          (copu),
        .atys          (atys)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [11:0] observe(input int sel);
        case (sel)
            S_FREQ:  return {1'b0, freq};
            S_COPU:  return {11'd0, copu};
            default: return {11'd0, atys};
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input logic [11:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic clear_strobes();
        apu_reset     = 1'b0;
        apu_wr        = 1'b0;
        ff13          = 1'b0;
        ff14          = 1'b0;
        ch1_restart   = 1'b0;
        ch1_ld_shift  = 1'b0;
        ch1_shift_clk = 1'b0;
        ch1_freq_upd1 = 1'b0;
        ch1_freq_upd2 = 1'b0;
        cnt_tick      = 1'b0;
    endtask

    // One clock edge with the currently driven inputs, then drain the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), e.val);
        end
        clear_strobes();
    endtask

    task automatic write_freq(input logic [10:0] v);
        apu_wr = 1'b1; ff13 = 1'b1; d = v[7:0];
        step();
        apu_wr = 1'b1; ff14 = 1'b1; d = {5'b10101, v[10:8]};
        step();
    endtask

    initial begin
        clear_strobes();

        // Reset and register writes
        apu_reset = 1'b1;
        expect_v("rst_freq", S_FREQ, 12'h000);
        expect_v("rst_copu", S_COPU, 12'h0);
        expect_v("rst_atys", S_ATYS, 12'h1);
        step();
        apu_wr = 1'b1; ff13 = 1'b1; d = 8'h34;
        step();
        apu_wr = 1'b1; ff14 = 1'b1; d = 8'h05;
        expect_v("wr_freq", S_FREQ, 12'h534);
        expect_v("wr_copu", S_COPU, 12'h0);
        expect_v("wr_atys", S_ATYS, 12'h1);
        step();

        // Period counter from 0x7FC: overflow on the fourth tick
        write_freq(11'h7FC);
        ch1_restart = 1'b1;
        expect_v("rs_copu", S_COPU, 12'h0);
        step();
        for (int i = 1; i <= 4; i++) begin
            cnt_tick = 1'b1;
            expect_v($sformatf("tick%0d_copu", i), S_COPU, (i == 4) ? 12'h1 : 12'h0);
            step();
        end
        expect_v("idle_copu", S_COPU, 12'h0);
        step();
        for (int i = 1; i <= 4; i++) begin
            cnt_tick = 1'b1;
            expect_v($sformatf("reload_tick%0d_copu", i), S_COPU, (i == 4) ? 12'h1 : 12'h0);
            step();
        end
        for (int i = 1; i <= 3; i++) begin
            cnt_tick = 1'b1;
            step();
        end
        ch1_restart = 1'b1; cnt_tick = 1'b1;
        expect_v("rs_tick_copu", S_COPU, 12'h0);
        step();
        cnt_tick = 1'b1;
        expect_v("after_rs_copu", S_COPU, 12'h0);
        step();

        // Mid-count write only takes effect at the next reload
        write_freq(11'h7FD);
        ch1_restart = 1'b1;
        step();
        apu_wr = 1'b1; ff13 = 1'b1; d = 8'hFF;
        step();
        for (int i = 1; i <= 3; i++) begin
            cnt_tick = 1'b1;
            expect_v($sformatf("midwr_tick%0d_copu", i), S_COPU, (i == 3) ? 12'h1 : 12'h0);
            step();
        end
        for (int i = 1; i <= 2; i++) begin
            cnt_tick = 1'b1;
            expect_v($sformatf("max_tick%0d_copu", i), S_COPU, 12'h1);
            step();
        end

        // Sweep add
        ff10_d3 = 1'b0;
        write_freq(11'h400);
        ch1_ld_shift = 1'b1;
        expect_v("add_ld_atys", S_ATYS, 12'h0);
        step();
        ch1_shift_clk = 1'b1;
        expect_v("add_sh1_atys", S_ATYS, 12'h1);
        step();
        ch1_freq_upd1 = 1'b1;
        expect_v("add_upd1_freq", S_FREQ, 12'h600);
        step();
        ch1_freq_upd2 = 1'b1;
        expect_v("add_upd2_freq", S_FREQ, 12'h600);
        expect_v("add_upd2_atys", S_ATYS, 12'h0);
        step();

        // Add overflow blocks the commit
        write_freq(11'h700);
        ch1_ld_shift = 1'b1;
        expect_v("ovf_atys", S_ATYS, 12'h0);
        step();
        ch1_freq_upd1 = 1'b1;
        expect_v("ovf_upd1_freq", S_FREQ, 12'h700);
        step();

        // Sweep subtract, including wrap below zero
        ff10_d3 = 1'b1;
        write_freq(11'h100);
        ch1_ld_shift = 1'b1;
        step();
        ch1_shift_clk = 1'b1;
        step();
        ch1_shift_clk = 1'b1;
        expect_v("sub_atys", S_ATYS, 12'h1);
        step();
        ch1_freq_upd1 = 1'b1;
        expect_v("sub_upd1_freq", S_FREQ, 12'h0C0);
        expect_v("sub_upd1_atys", S_ATYS, 12'h1);
        step();
        ch1_freq_upd2 = 1'b1;
        step();
        ch1_freq_upd1 = 1'b1;
        expect_v("sub_zero_freq", S_FREQ, 12'h000);
        step();
        ch1_freq_upd1 = 1'b1;
        expect_v("sub_wrap_freq", S_FREQ, 12'h740);
        expect_v("sub_wrap_atys", S_ATYS, 12'h1);
        step();

        // Priority: load beats shift, upd2 beats shift
        ff10_d3 = 1'b0;
        write_freq(11'h100);
        ch1_ld_shift = 1'b1; ch1_shift_clk = 1'b1;
        step();
        ch1_freq_upd1 = 1'b1;
        expect_v("ld_shift_freq", S_FREQ, 12'h200);
        step();
        ch1_freq_upd2 = 1'b1; ch1_shift_clk = 1'b1;
        step();
        ch1_freq_upd1 = 1'b1;
        expect_v("upd2_shift_freq", S_FREQ, 12'h400);
        step();

        // CPU write wins over upd1 on its bits only
        apu_reset = 1'b1;
        step();
        write_freq(11'h123);
        ch1_freq_upd1 = 1'b1; apu_wr = 1'b1; ff14 = 1'b1; d = 8'h07;
        expect_v("wr_upd1_freq", S_FREQ, 12'h723);
        step();

        // Reset beats upd1
        ch1_ld_shift = 1'b1;
        step();
        ff10_d3 = 1'b1;
        apu_reset = 1'b1; ch1_freq_upd1 = 1'b1;
        expect_v("rst_upd1_freq", S_FREQ, 12'h000);
        expect_v("rst_upd1_atys", S_ATYS, 12'h1);
        step();
        ff10_d3 = 1'b0;

        // Reset mid-count clears the counter
        write_freq(11'h7FE);
        ch1_restart = 1'b1;
        step();
        cnt_tick = 1'b1;
        step();
        apu_reset = 1'b1;
        expect_v("midrst_copu", S_COPU, 12'h0);
        step();
        cnt_tick = 1'b1;
        expect_v("midrst_tick_copu", S_COPU, 12'h0);
        step();
        ch1_restart = 1'b1;
        expect_v("midrst_rs_freq", S_FREQ, 12'h000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
